rr_decoder_arbiter: RTL

//  - Round-robin arbiter sharing one resource among 16 requesters; the winner is

---
 rtl/rr_decoder_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rr_decoder_arbiter.sv
// Purpose : round-robin arbiter sharing one resource among 16 requesters, grant driven through a 4-to-16 decoder.
// Latency : req to grant is 1 clock; a holder hands over to the next requester with no idle bubble.
// Backpr. : the holder keeps the grant until i_done or its request drops; optional hold-limit preemption.
//
// Ports:
//   i_clk         rising-edge clock
//   i_rst_n       synchronous reset, active-low
//   i_req         request vector, bit i = requester i
//   i_done        current holder releases the resource this cycle (ignored while idle)
//   o_grant_idx   registered winner index (decoder binary input)
//   o_grant_valid registered grant-active flag (decoder enable)
//   o_grant       one-hot grant bus, decoded from o_grant_idx / o_grant_valid
//   o_timeout     one-cycle pulse on forced preemption
//
// Optional feature macro: RR_ARB_TIMEOUT_EN
//   defined   : a holder that has held HOLD_MAX cycles while others wait is forcibly released
//   undefined : no hold counter, o_timeout tied low

// 4-to-16 decoder: one-hot output of the binary input when enabled, all-zero otherwise.
// Purely combinational; no state.
module rr_decoder_4to16 (
    input  logic [3:0]  i_binary,
    input  logic        i_enable,
    output logic [15:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_enable) begin
            o_onehot[i_binary] = 1'b1;
        end
    end

endmodule

module rr_decoder_arbiter #(
    parameter int NUM_REQ  = 16,
    parameter int HOLD_MAX = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_done,
    output logic [3:0]         o_grant_idx,
    output logic               o_grant_valid,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_timeout
);

    localparam int IDX_W = 4;

    // The requester count is pinned by the 4-bit decoder; reject any other build.
    generate
        if (NUM_REQ != 16) begin : g_bad_num_req
            $error("rr_decoder_arbiter: NUM_REQ must be 16");
        end
        if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
            $error("rr_decoder_arbiter: HOLD_MAX must be in 2..255");
        end
    endgenerate

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant_idx;
    logic               r_grant_valid;

    logic               w_hold;
    logic               w_preempt;
    logic               w_keep;
    logic               w_take;
    logic [NUM_REQ-1:0] w_search_req;
    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_off;
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;

    // Holder still wants the resource and has not signalled completion.
    assign w_hold = (r_state == S_GRANT) && i_req[r_grant_idx] && !i_done;

    // Candidates for the search. On a forced preemption the holder is removed
    // so the resource is guaranteed to move to somebody else.
    always_comb begin
        w_search_req = i_req;
        if (w_preempt) begin
            w_search_req = i_req & ~o_grant;
        end
    end

    // Rotating search starting at r_ptr. Every grant loads r_ptr with
    // winner+1, so while granting r_ptr is grant_idx+1 and the holder sits
    // last in priority; in IDLE it continues from where the last grant left off.
    assign w_rot = NUM_REQ'({w_search_req, w_search_req} >> r_ptr);

    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign w_found  = |w_search_req;
    assign w_winner = r_ptr + w_off;  // 4-bit add gives the mod-16 wrap

    // Keep the current grant untouched, or start a new one this edge.
    assign w_keep = w_hold && !w_preempt;
    assign w_take = !w_keep && w_found;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state       <= S_GRANT;
                        r_grant_idx   <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_ptr         <= w_winner + 4'd1;
                    end
                end
                S_GRANT: begin
                    if (w_take) begin
                        // Hand-over (possibly back to a sole requester), no bubble.
                        r_grant_idx   <= w_winner;
                        r_ptr         <= w_winner + 4'd1;
                    end else if (!w_keep) begin
                        // Released and nobody waiting; index keeps its last value.
                        r_state       <= S_IDLE;
                        r_grant_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] r_hold_cnt;
    logic       r_timeout;

    // Preempt only a holder that would otherwise keep the grant, has used up
    // its share, and has at least one competitor waiting.
    assign w_preempt = w_hold && (r_hold_cnt == HOLD_LAST) && |(i_req & ~o_grant);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_preempt;
            if (w_take) begin
                r_hold_cnt <= '0;
            end else if (w_keep && (r_hold_cnt != HOLD_LAST)) begin
                // Saturates so a sole requester is never preempted.
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_preempt = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_grant_idx   = r_grant_idx;
    assign o_grant_valid = r_grant_valid;

    // Decoded straight from registers, so the grant bus cannot glitch on req/done.
    rr_decoder_4to16 u_decoder (
        .i_binary (r_grant_idx),
        .i_enable (r_grant_valid),
        .o_onehot (o_grant)
    );

endmodule
